// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, threshold flags,
// sticky overflow/underflow errors and optional first-word-fall-through read.
module sync_fifo_flags #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             r_en,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_unf;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [PW-1:0]    w_wr_ptr_nxt;
  logic [PW-1:0]    w_rd_ptr_nxt;

  // Accept decisions use only the pre-edge flags: a same-cycle read never
  // makes room for a write, and a same-cycle write never feeds a read.
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = w_en && !w_full;
  assign w_rd_acc = r_en && !w_empty;

  // Explicit wrap so non-power-of-two depths work.
  assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

  // Storage array: written on accepted writes, never reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_rd_acc) r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a new offending request wins over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_en && w_full)  r_ovf <= 1'b1;
      else if (err_clr)    r_ovf <= 1'b0;
      if (r_en && w_empty) r_unf <= 1'b1;
      else if (err_clr)    r_unf <= 1'b0;
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [WIDTH-1:0] r_dout;
      // Registered read: capture the head word on an accepted read, hold otherwise.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_dout <= '0;
        end else if (w_rd_acc) begin
          r_dout <= r_mem[r_rd_ptr];
        end
      end
      assign data_out = r_dout;
    end else begin : g_fwft_read
      // Head word is always presented; meaningless while empty.
      assign data_out = r_mem[r_rd_ptr];
    end
  endgenerate

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= CW'(AF_THRESH));
  assign almost_empty = (r_count <= CW'(AE_THRESH));
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: three instances share one stimulus stream
// (DEPTH=8 registered read, DEPTH=8 FWFT, DEPTH=5 registered read).
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] a_dout, b_dout, c_dout;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic       c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
  logic [3:0] a_cnt, b_cnt;
  logic [2:0] c_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DEPTH(8), .WIDTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(a_dout), .full(a_full), .empty(a_empty), .almost_full(a_af),
    .almost_empty(a_ae), .count(a_cnt), .overflow(a_ovf), .underflow(a_unf),
    .err_clr(err_clr));

  sync_fifo_flags #(.DEPTH(8), .WIDTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(b_dout), .full(b_full), .empty(b_empty), .almost_full(b_af),
    .almost_empty(b_ae), .count(b_cnt), .overflow(b_ovf), .underflow(b_unf),
    .err_clr(err_clr));

  sync_fifo_flags #(.DEPTH(5), .WIDTH(8), .AF_THRESH(4), .AE_THRESH(1), .FWFT(0)) u_c (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(c_dout), .full(c_full), .empty(c_empty), .almost_full(c_af),
    .almost_empty(c_ae), .count(c_cnt), .overflow(c_ovf), .underflow(c_unf),
    .err_clr(err_clr));

  // Drive one cycle of stimulus, then land 1 time unit after the edge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic c);
    w_en = w; r_en = r; data_in = d; err_clr = c;
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    w_en = 0; r_en = 0; err_clr = 0; data_in = 0;
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [7:0] st;
    reset_dut();
    cyc(0, 1, 8'h00, 0);
    cyc(1, 0, 8'h11, 0);
    cyc(1, 0, 8'h22, 0);
    cyc(1, 0, 8'h33, 0);
    cyc(1, 1, 8'h44, 0);
    #2 rst_n = 1'b0;
    #1;
    st = {a_empty, a_ae, a_full, a_af, a_ovf, a_unf, 2'b00};
    n_tests++;
    if (a_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", a_cnt); end
    n_tests++;
    if (st !== 8'b1100_0000) begin n_fail++; $display("FAIL reset_flags got %b exp 11000000", st); end
    n_tests++;
    if (a_dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h exp 00", a_dout); end
    w_en = 0; r_en = 0;
    #2 rst_n = 1'b1;
    cyc(1, 0, 8'h77, 0);
    cyc(0, 1, 8'h00, 0);
    n_tests++;
    if (a_dout !== 8'h77) begin n_fail++; $display("FAIL reset_first_word got %h exp 77", a_dout); end
    n_tests++;
    if (a_empty !== 1'b1) begin n_fail++; $display("FAIL reset_drain_empty got %b exp 1", a_empty); end
  endtask

  task automatic test_fill_drain();
    reset_dut();
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 0, 8'(k), 0);
      n_tests++;
      if (a_cnt !== 4'(k)) begin n_fail++; $display("FAIL fill_count k=%0d got %0d exp %0d", k, a_cnt, k); end
      n_tests++;
      if ({a_full, a_af, a_ae} !== {k == 8, k >= 6, k <= 2})
        begin n_fail++; $display("FAIL fill_flags k=%0d got %b exp %b", k, {a_full, a_af, a_ae}, {k == 8, k >= 6, k <= 2}); end
    end
    cyc(1, 0, 8'h09, 0);
    n_tests++;
    if ({a_ovf, a_full, a_cnt} !== {1'b1, 1'b1, 4'd8})
      begin n_fail++; $display("FAIL extra_write got ovf=%b full=%b cnt=%0d exp 1 1 8", a_ovf, a_full, a_cnt); end
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 8'h00, 0);
      n_tests++;
      if (a_dout !== 8'(i)) begin n_fail++; $display("FAIL drain_data i=%0d got %h exp %h", i, a_dout, 8'(i)); end
      n_tests++;
      if ({a_cnt, a_empty} !== {4'(8 - i), i == 8})
        begin n_fail++; $display("FAIL drain_state i=%0d got cnt=%0d empty=%b", i, a_cnt, a_empty); end
    end
    cyc(0, 0, 8'h00, 0);
    n_tests++;
    if (a_dout !== 8'h08) begin n_fail++; $display("FAIL dout_hold got %h exp 08", a_dout); end
  endtask

  task automatic test_underflow();
    cyc(0, 1, 8'h00, 0);
    n_tests++;
    if ({a_unf, a_cnt, a_dout} !== {1'b1, 4'd0, 8'h08})
      begin n_fail++; $display("FAIL underflow_set got unf=%b cnt=%0d dout=%h", a_unf, a_cnt, a_dout); end
    cyc(0, 1, 8'h00, 1);
    n_tests++;
    if ({a_unf, a_ovf} !== 2'b10)
      begin n_fail++; $display("FAIL set_wins_clear got unf=%b ovf=%b exp 1 0", a_unf, a_ovf); end
    cyc(0, 0, 8'h00, 1);
    n_tests++;
    if (a_unf !== 1'b0) begin n_fail++; $display("FAIL underflow_clear got %b exp 0", a_unf); end
  endtask

  task automatic test_empty_rw();
    cyc(1, 1, 8'h3C, 0);
    n_tests++;
    if ({a_cnt, a_unf, a_empty, a_dout} !== {4'd1, 1'b1, 1'b0, 8'h08})
      begin n_fail++; $display("FAIL empty_rw got cnt=%0d unf=%b empty=%b dout=%h", a_cnt, a_unf, a_empty, a_dout); end
    cyc(0, 1, 8'h00, 1);
    n_tests++;
    if ({a_cnt, a_unf, a_dout} !== {4'd0, 1'b0, 8'h3C})
      begin n_fail++; $display("FAIL empty_rw_read got cnt=%0d unf=%b dout=%h", a_cnt, a_unf, a_dout); end
  endtask

  task automatic test_full_rw();
    reset_dut();
    for (int k = 1; k <= 8; k++) cyc(1, 0, 8'(k), 0);
    cyc(1, 1, 8'hAA, 0);
    n_tests++;
    if ({a_dout, a_cnt, a_ovf, a_full} !== {8'h01, 4'd7, 1'b1, 1'b0})
      begin n_fail++; $display("FAIL full_rw got dout=%h cnt=%0d ovf=%b full=%b", a_dout, a_cnt, a_ovf, a_full); end
    cyc(1, 0, 8'h09, 0);
    n_tests++;
    if (a_cnt !== 4'd8) begin n_fail++; $display("FAIL full_rw_refill got %0d exp 8", a_cnt); end
    for (int i = 2; i <= 9; i++) begin
      cyc(0, 1, 8'h00, 0);
      n_tests++;
      if (a_dout !== 8'(i)) begin n_fail++; $display("FAIL wrap_drain got %h exp %h", a_dout, 8'(i)); end
    end
  endtask

  task automatic test_fwft();
    reset_dut();
    cyc(1, 0, 8'hA5, 0);
    n_tests++;
    if ({b_empty, b_dout} !== {1'b0, 8'hA5})
      begin n_fail++; $display("FAIL fwft_first got empty=%b dout=%h exp 0 a5", b_empty, b_dout); end
    cyc(0, 0, 8'h00, 0);
    n_tests++;
    if ({b_empty, b_dout} !== {1'b0, 8'hA5})
      begin n_fail++; $display("FAIL fwft_hold got empty=%b dout=%h exp 0 a5", b_empty, b_dout); end
    cyc(0, 1, 8'h00, 0);
    n_tests++;
    if (b_empty !== 1'b1) begin n_fail++; $display("FAIL fwft_pop got empty=%b exp 1", b_empty); end
    cyc(1, 0, 8'h5A, 0);
    cyc(1, 0, 8'hC3, 0);
    n_tests++;
    if (b_dout !== 8'h5A) begin n_fail++; $display("FAIL fwft_head got %h exp 5a", b_dout); end
    cyc(0, 1, 8'h00, 0);
    n_tests++;
    if ({b_dout, b_cnt} !== {8'hC3, 4'd1})
      begin n_fail++; $display("FAIL fwft_next got dout=%h cnt=%0d exp c3 1", b_dout, b_cnt); end
  endtask

  // Queue-based reference for the two registered-read instances.
  task automatic test_random();
    logic [7:0] qa[$];
    logic [7:0] qc[$];
    logic [7:0] da, dc;
    logic       oa, ua, oc, uc, w, r, c;
    logic [7:0] d;
    logic [17:0] ea, ec, ga, gc;
    int         pw, errs;
    reset_dut();
    da = 0; dc = 0; oa = 0; ua = 0; oc = 0; uc = 0; errs = 0;
    for (int t = 0; t < 10000; t++) begin
      pw = ((t / 400) % 2 == 0) ? 70 : 30;
      w = ($urandom_range(99) < pw);
      r = ($urandom_range(99) < (100 - pw));
      c = ($urandom_range(15) == 0);
      d = 8'($urandom);
      if (w && qa.size() == 8) oa = 1; else if (c) oa = 0;
      if (r && qa.size() == 0) ua = 1; else if (c) ua = 0;
      if (w && qc.size() == 5) oc = 1; else if (c) oc = 0;
      if (r && qc.size() == 0) uc = 1; else if (c) uc = 0;
      begin
        bit wa, ra, wc, rc;
        wa = w && qa.size() != 8; ra = r && qa.size() != 0;
        wc = w && qc.size() != 5; rc = r && qc.size() != 0;
        if (ra) da = qa.pop_front();
        if (wa) qa.push_back(d);
        if (rc) dc = qc.pop_front();
        if (wc) qc.push_back(d);
      end
      cyc(w, r, d, c);
      ea = {4'(qa.size()), qa.size() == 8, qa.size() == 0, qa.size() >= 6, qa.size() <= 2, oa, ua, da};
      ga = {a_cnt, a_full, a_empty, a_af, a_ae, a_ovf, a_unf, a_dout};
      ec = {4'(qc.size()), qc.size() == 5, qc.size() == 0, qc.size() >= 4, qc.size() <= 1, oc, uc, dc};
      gc = {1'b0, c_cnt, c_full, c_empty, c_af, c_ae, c_ovf, c_unf, c_dout};
      n_tests++;
      if (ga !== ea) begin
        n_fail++;
        if (errs < 10) $display("FAIL rand_d8 t=%0d got %h exp %h", t, ga, ea);
        errs++;
      end
      n_tests++;
      if (gc !== ec) begin
        n_fail++;
        if (errs < 10) $display("FAIL rand_d5 t=%0d got %h exp %h", t, gc, ec);
        errs++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_underflow();
    test_empty_rw();
    test_full_rw();
    test_fwft();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
